// File: rtl/instr_decode_stage_if.sv
// Handshake and decoded-field bundle between fetch, the decode stage and the register file / control unit.
// master drives the fetch side and consumes the decoded beat; slave is the decode stage itself.
interface instr_decode_stage_if #(
  parameter int INSTR_LEN  = 32,
  parameter int DATA_WIDTH = 64,
  parameter int PC_WIDTH   = 64,
  parameter int CNT_WIDTH  = 16
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [INSTR_LEN-1:0]  instruction;
  logic [PC_WIDTH-1:0]   pc_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [10:0]           opcode;
  logic [4:0]            rm_num;
  logic [4:0]            rn_num;
  logic [4:0]            rd_num;
  logic [8:0]            address;
  logic [2:0]            fmt;
  logic [DATA_WIDTH-1:0] imm_ext;
  logic [PC_WIDTH-1:0]   pc_out;
  logic [CNT_WIDTH-1:0]  illegal_cnt;

  modport master (
    output flush, in_valid, instruction, pc_in, out_ready,
    input  in_ready, out_valid, opcode, rm_num, rn_num, rd_num, address,
           fmt, imm_ext, pc_out, illegal_cnt
  );

  modport slave (
    input  flush, in_valid, instruction, pc_in, out_ready,
    output in_ready, out_valid, opcode, rm_num, rn_num, rd_num, address,
           fmt, imm_ext, pc_out, illegal_cnt
  );
endinterface

// File: rtl/instr_decode_stage.sv
// LEGv8 decode stage: combinational field split / format classification feeding a
// two-entry (OUT + SKID) buffer so in_ready is registered and throughput stays 1 beat/cycle.
module instr_decode_stage #(
  parameter int INSTR_LEN  = 32,
  parameter int DATA_WIDTH = 64,
  parameter int PC_WIDTH   = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_decode_stage_if.slave   bus
);

  localparam logic [2:0] FMT_ILLEGAL = 3'd0;
  localparam logic [2:0] FMT_R       = 3'd1;
  localparam logic [2:0] FMT_I       = 3'd2;
  localparam logic [2:0] FMT_D       = 3'd3;
  localparam logic [2:0] FMT_B       = 3'd4;
  localparam logic [2:0] FMT_CB      = 3'd5;
  localparam logic [2:0] FMT_IW      = 3'd6;

  typedef struct packed {
    logic [10:0]           opcode;
    logic [4:0]            rm_num;
    logic [4:0]            rn_num;
    logic [4:0]            rd_num;
    logic [8:0]            address;
    logic [2:0]            fmt;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [PC_WIDTH-1:0]   pc;
  } beat_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  logic [31:0]          instr_s;
  beat_t                dec_s;
  beat_t                out_r;
  beat_t                skid_r;
  state_t               state_r;
  state_t               state_nx_s;
  logic                 out_valid_r;
  logic                 in_ready_r;
  logic                 accept_s;
  logic                 load_out_in_s;
  logic                 load_out_skid_s;
  logic                 load_skid_s;
  logic [CNT_WIDTH-1:0] illegal_cnt_r;

  assign instr_s  = bus.instruction[31:0];
  assign accept_s = bus.in_valid && in_ready_r && !bus.flush;

  // Split fields and classify format; match order resolves overlapping opcode ranges.
  always_comb begin
    dec_s         = '0;
    dec_s.opcode  = instr_s[31:21];
    dec_s.rm_num  = instr_s[20:16];
    dec_s.rn_num  = instr_s[9:5];
    dec_s.rd_num  = instr_s[4:0];
    dec_s.address = instr_s[20:12];
    dec_s.pc      = bus.pc_in;
    if (instr_s[31:26] == 6'b000101) begin
      dec_s.fmt     = FMT_B;
      dec_s.imm_ext = {{(DATA_WIDTH-26){instr_s[25]}}, instr_s[25:0]};
    end else if (instr_s[31:25] == 7'b1011010) begin
      dec_s.fmt     = FMT_CB;
      dec_s.imm_ext = {{(DATA_WIDTH-19){instr_s[23]}}, instr_s[23:5]};
    end else if (instr_s[31:23] == 9'b110100101) begin
      dec_s.fmt     = FMT_IW;
      dec_s.imm_ext = {{(DATA_WIDTH-16){1'b0}}, instr_s[20:5]};
    end else if ((instr_s[31:22] == 10'b1001000100) || (instr_s[31:22] == 10'b1101000100)) begin
      dec_s.fmt     = FMT_I;
      dec_s.imm_ext = {{(DATA_WIDTH-12){1'b0}}, instr_s[21:10]};
    end else if ((instr_s[31:21] == 11'd1986) || (instr_s[31:21] == 11'd1984)) begin
      dec_s.fmt     = FMT_D;
      dec_s.imm_ext = {{(DATA_WIDTH-9){instr_s[20]}}, instr_s[20:12]};
    end else if (instr_s[31:21] inside {11'd1112, 11'd1624, 11'd1104, 11'd1360, 11'd1691, 11'd1690}) begin
      dec_s.fmt     = FMT_R;
      dec_s.imm_ext = {{(DATA_WIDTH-6){1'b0}}, instr_s[15:10]};
    end else begin
      dec_s.fmt     = FMT_ILLEGAL;
      dec_s.imm_ext = '0;
    end
  end

  // Buffer next-state and load selects; flush overrides any accept or drain.
  always_comb begin
    state_nx_s      = state_r;
    load_out_in_s   = 1'b0;
    load_out_skid_s = 1'b0;
    load_skid_s     = 1'b0;
    if (bus.flush) begin
      state_nx_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_nx_s    = ST_ONE;
            load_out_in_s = 1'b1;
          end else begin
            state_nx_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && bus.out_ready) begin
            state_nx_s    = ST_ONE;
            load_out_in_s = 1'b1;
          end else if (accept_s) begin
            state_nx_s  = ST_FULL;
            load_skid_s = 1'b1;
          end else if (bus.out_ready) begin
            state_nx_s = ST_EMPTY;
          end else begin
            state_nx_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (bus.out_ready) begin
            state_nx_s      = ST_ONE;
            load_out_skid_s = 1'b1;
          end else begin
            state_nx_s = ST_FULL;
          end
        end
        default: begin
          state_nx_s = ST_EMPTY;
        end
      endcase
    end
  end

  // State register with handshake flags registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_nx_s;
      out_valid_r <= (state_nx_s != ST_EMPTY);
      in_ready_r  <= (state_nx_s != ST_FULL);
    end
  end

  // Payload registers and saturating illegal counter (flush leaves the count alone).
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r         <= '0;
      skid_r        <= '0;
      illegal_cnt_r <= '0;
    end else begin
      if (load_out_in_s) begin
        out_r <= dec_s;
      end else if (load_out_skid_s) begin
        out_r <= skid_r;
      end else begin
        out_r <= out_r;
      end
      if (load_skid_s) begin
        skid_r <= dec_s;
      end else begin
        skid_r <= skid_r;
      end
      if (accept_s && (dec_s.fmt == FMT_ILLEGAL) && (illegal_cnt_r != {CNT_WIDTH{1'b1}})) begin
        illegal_cnt_r <= illegal_cnt_r + CNT_WIDTH'(1'b1);
      end else begin
        illegal_cnt_r <= illegal_cnt_r;
      end
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.opcode      = out_r.opcode;
  assign bus.rm_num      = out_r.rm_num;
  assign bus.rn_num      = out_r.rn_num;
  assign bus.rd_num      = out_r.rd_num;
  assign bus.address     = out_r.address;
  assign bus.fmt         = out_r.fmt;
  assign bus.imm_ext     = out_r.imm_ext;
  assign bus.pc_out      = out_r.pc;
  assign bus.illegal_cnt = illegal_cnt_r;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: hand-decoded LEGv8 vectors, back-pressure,
// flush and illegal-counter saturation (CNT_WIDTH=2 so saturation is reachable).
module tb_instr_decode_stage;

  logic clk;
  logic rst;
  int   total_cnt;
  int   bad_cnt;

  instr_decode_stage_if #(.INSTR_LEN(32), .DATA_WIDTH(64), .PC_WIDTH(64), .CNT_WIDTH(2)) bus ();

  instr_decode_stage #(.INSTR_LEN(32), .DATA_WIDTH(64), .PC_WIDTH(64), .CNT_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [63:0] pc);
    bus.in_valid    = 1'b1;
    bus.instruction = instr;
    bus.pc_in       = pc;
  endtask

  task automatic check_beat(input string tag, input logic [2:0] fmt, input logic [63:0] imm, input logic [63:0] pc);
    check_val({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
    check_val({tag, ".fmt"},   64'(bus.fmt),       64'(fmt));
    check_val({tag, ".imm"},   bus.imm_ext,        imm);
    check_val({tag, ".pc"},    bus.pc_out,         pc);
  endtask

  initial begin
    total_cnt       = 0;
    bad_cnt         = 0;
    rst             = 1'b1;
    bus.flush       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.instruction = 32'h0;
    bus.pc_in       = 64'h0;
    bus.out_ready   = 1'b1;

    // reset state
    step();
    step();
    check_val("rst.out_valid", 64'(bus.out_valid),   64'd0);
    check_val("rst.in_ready",  64'(bus.in_ready),    64'd1);
    check_val("rst.cnt",       64'(bus.illegal_cnt), 64'd0);
    check_val("rst.fmt",       64'(bus.fmt),         64'd0);
    check_val("rst.imm",       bus.imm_ext,          64'd0);
    rst = 1'b0;
    step();

    // LDUR X9,[X22,#240] then [X22,#-8]
    present(32'hF84F02C9, 64'h100);
    step();
    check_beat("ldur", 3'd3, 64'd240, 64'h100);
    check_val("ldur.opcode", 64'(bus.opcode),  64'd1986);
    check_val("ldur.rn",     64'(bus.rn_num),  64'd22);
    check_val("ldur.rd",     64'(bus.rd_num),  64'd9);
    check_val("ldur.addr",   64'(bus.address), 64'd240);
    present(32'hF85F82C9, 64'h104);
    step();
    check_beat("ldurneg", 3'd3, 64'hFFFF_FFFF_FFFF_FFF8, 64'h104);
    check_val("ldurneg.addr", 64'(bus.address), 64'h1F8);

    // ADD X10,X21,X9 then CBZ X3,#-2 back-to-back
    present(32'h8B0902AA, 64'h108);
    step();
    check_beat("add", 3'd1, 64'd0, 64'h108);
    check_val("add.opcode", 64'(bus.opcode), 64'd1112);
    check_val("add.rm",     64'(bus.rm_num), 64'd9);
    check_val("add.rn",     64'(bus.rn_num), 64'd21);
    check_val("add.rd",     64'(bus.rd_num), 64'd10);
    present(32'hB4FFFFC3, 64'h10C);
    step();
    check_beat("cbz", 3'd5, 64'hFFFF_FFFF_FFFF_FFFE, 64'h10C);
    check_val("cbz.rd", 64'(bus.rd_num), 64'd3);
    // LSL X1,X2,#3: R format with shamt
    present(32'hD3600C41, 64'h110);
    step();
    check_beat("lsl", 3'd1, 64'd3, 64'h110);
    bus.in_valid = 1'b0;
    step();
    check_val("drain.out_valid", 64'(bus.out_valid), 64'd0);

    // back-pressure: A=ADDI #5, B=MOVZ #0xBEEF, C=B #-1
    bus.out_ready = 1'b0;
    present(32'h91001441, 64'h200);
    step();
    check_beat("bp.a0", 3'd2, 64'd5, 64'h200);
    present(32'hD297DDE7, 64'h204);
    step();
    check_val("bp.full.in_ready", 64'(bus.in_ready), 64'd0);
    check_beat("bp.a1", 3'd2, 64'd5, 64'h200);
    present(32'h17FFFFFF, 64'h208);
    step();
    check_val("bp.stall.in_ready", 64'(bus.in_ready), 64'd0);
    check_beat("bp.a2", 3'd2, 64'd5, 64'h200);
    bus.out_ready = 1'b1;
    step();
    check_beat("bp.b", 3'd6, 64'hBEEF, 64'h204);
    step();
    check_beat("bp.c", 3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h208);
    bus.in_valid = 1'b0;
    step();
    check_val("bp.empty", 64'(bus.out_valid), 64'd0);

    // flush in ONE with an acceptable beat presented
    bus.out_ready = 1'b0;
    present(32'h91001441, 64'h300);
    step();
    present(32'hD297DDE7, 64'h304);
    bus.flush = 1'b1;
    step();
    check_val("fl1.out_valid", 64'(bus.out_valid), 64'd0);
    check_val("fl1.in_ready",  64'(bus.in_ready),  64'd1);
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check_val("fl1.no_ghost", 64'(bus.out_valid), 64'd0);

    // flush in FULL with a new beat presented
    bus.out_ready = 1'b0;
    present(32'h91001441, 64'h400);
    step();
    present(32'hD297DDE7, 64'h404);
    step();
    check_val("fl2.full", 64'(bus.in_ready), 64'd0);
    present(32'h17FFFFFF, 64'h408);
    bus.flush = 1'b1;
    step();
    check_val("fl2.out_valid", 64'(bus.out_valid), 64'd0);
    check_val("fl2.in_ready",  64'(bus.in_ready),  64'd1);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    present(32'hD3600C41, 64'h40C);
    step();
    check_beat("fl2.next", 3'd1, 64'd3, 64'h40C);
    bus.in_valid = 1'b0;
    step();

    // illegal beats: count to 3, then saturate at 3 (CNT_WIDTH=2)
    present(32'h0000_0000, 64'h500);
    step();
    check_val("ill.cnt1", 64'(bus.illegal_cnt), 64'd1);
    step();
    step();
    check_beat("ill", 3'd0, 64'd0, 64'h500);
    check_val("ill.cnt3", 64'(bus.illegal_cnt), 64'd3);
    step();
    step();
    bus.in_valid = 1'b0;
    step();
    check_val("ill.sat", 64'(bus.illegal_cnt), 64'd3);

    // reset mid-operation from FULL
    bus.out_ready = 1'b0;
    present(32'h91001441, 64'h600);
    step();
    present(32'hD297DDE7, 64'h604);
    step();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    check_val("rst2.out_valid", 64'(bus.out_valid),   64'd0);
    check_val("rst2.in_ready",  64'(bus.in_ready),    64'd1);
    check_val("rst2.cnt",       64'(bus.illegal_cnt), 64'd0);
    check_val("rst2.pc",        bus.pc_out,           64'd0);
    check_val("rst2.imm",       bus.imm_ext,          64'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check_val("rst2.still_empty", 64'(bus.out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Registered, flow-controlled LEGv8 instruction decode stage. Sits between the fetch stage and the register file / control unit. Splits each 32-bit instruction into opcode and register fields, classifies its format, and produces a format-correct extended immediate. A two-entry (output + skid) buffer gives full throughput under back-pressure, plus a flush for branch redirects.

## Interface
Parameters:
- INSTR_LEN, 32, instruction width; only 32 is supported.
- DATA_WIDTH, 64, width of `imm_ext`.
- PC_WIDTH, 64, width of `pc_in`/`pc_out`.
- CNT_WIDTH, 16, width of the illegal-instruction counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all buffered and in-flight instructions.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- instruction  in  INSTR_LEN  raw machine code.
- pc_in  in  PC_WIDTH  PC of `instruction`.
- out_valid  out  1  decoded beat valid.
- out_ready  in  1  downstream accepts the beat.
- opcode  out  11  instr[31:21].
- rm_num  out  5  instr[20:16].
- rn_num  out  5  instr[9:5].
- rd_num  out  5  instr[4:0]; this is Rt for D/CB.
- address  out  9  instr[20:12].
- fmt  out  3  format: 0 ILLEGAL, 1 R, 2 I, 3 D, 4 B, 5 CB, 6 IW.
- imm_ext  out  DATA_WIDTH  extended immediate.
- pc_out  out  PC_WIDTH  PC of the decoded beat.
- illegal_cnt  out  CNT_WIDTH  saturating count of accepted ILLEGAL beats.

## Operation
- Decode is combinational on the input side. Stored fields are already decoded.
- Raw fields (`opcode`, `rm_num`, `rn_num`, `rd_num`, `address`) are always extracted, regardless of format.
- Format is selected by opcode match, checked in this order:
  - B: instr[31:26]=000101.
  - CB: instr[31:24]=10110100 (CBZ) or 10110101 (CBNZ).
  - IW: instr[31:23]=110100101 (MOVZ).
  - I: instr[31:22]=1001000100 (ADDI) or 1101000100 (SUBI).
  - D: opcode 1986 (LDUR) or 1984 (STUR).
  - R: opcode 1112 ADD, 1624 SUB, 1104 AND, 1360 ORR, 1691 LSL, 1690 LSR.
  - Anything else is ILLEGAL.
- `imm_ext` by format:
  - R: zero-extend shamt instr[15:10].
  - I: zero-extend instr[21:10].
  - D: sign-extend instr[20:12].
  - B: sign-extend instr[25:0].
  - CB: sign-extend instr[23:5].
  - IW: zero-extend instr[20:5].
  - ILLEGAL: 0.
  - No left shift is applied; the branch unit scales offsets.
- Buffer: output register OUT plus skid register SKID. States are EMPTY (OUT invalid), ONE (OUT valid), FULL (OUT and SKID valid).
  - EMPTY + accept → ONE.
  - ONE + accept + out_ready → ONE; the new beat replaces OUT.
  - ONE + accept + !out_ready → FULL; the new beat goes to SKID.
  - ONE + out_ready, no accept → EMPTY.
  - FULL + out_ready → ONE; SKID moves to OUT.
  - FULL + !out_ready → FULL; hold.
- `in_ready` = !SKID.valid, driven directly from a register (no combinational path from `out_ready`).
- Accept = in_valid && in_ready && !flush.
- Order is preserved. No beat is duplicated or dropped except by flush.
- `illegal_cnt` increments on each accepted ILLEGAL beat and saturates at all-ones. Flush does not clear it.

## Timing
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N; it is visible in cycle N+1.
- Throughput: 1 beat/cycle while out_ready=1.
- Payload outputs are stable while out_valid && !out_ready.
- Reset (synchronous, takes effect at the edge with rst=1):
  - out_valid=0, SKID empty, in_ready=1 from the next cycle.
  - All payload outputs = 0, fmt=0, illegal_cnt=0.
  - Reset mid-operation discards OUT and SKID.
- flush=1 at edge N: OUT and SKID are invalidated and out_valid=0 after N. The input beat presented in that cycle is discarded even if in_valid && in_ready. rst has priority over flush.
- The downstream handshake completing in the same cycle as flush is still counted as consumed by the receiver.
- Simultaneous accept and drain in ONE: the new beat lands in OUT with no bubble.

## Test plan
- Reset: hold rst 2 cycles → out_valid=0, in_ready=1, illegal_cnt=0, fmt=0, imm_ext=0.
- Send 0xF84F02C9 (LDUR X9,[X22,#240]) with out_ready=1 → next cycle: fmt=3, opcode=1986, rn=22, rd=9, address=240, imm_ext=240. Then send 0xF85F82C9 ([X22,#-8]) → address=0x1F8, imm_ext=0xFFFF_FFFF_FFFF_FFF8.
- Send 0x8B0902AA (ADD X10,X21,X9) followed by 0xB4FFFFC3 (CBZ X3,#-2) back-to-back → consecutive cycles show:
  - fmt=1, rm=9, rn=21, rd=10, imm_ext=0;
  - then fmt=5, rd=3, imm_ext=all-ones minus 1 (−2).
- Back-pressure: out_ready=0, stream 3 beats A,B,C → A held in OUT, B in SKID, in_ready=0, C stalls. Raise out_ready → A, B, C emerge in order on consecutive cycles, none lost.
- Flush in FULL state with a new beat presented → next cycle out_valid=0, in_ready=1. The presented beat never appears.
- Send 0x00000000 three times → fmt=0, imm_ext=0, illegal_cnt=3. With CNT_WIDTH=2, send 5 such beats → illegal_cnt saturates at 3.
